// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared types and byte constants for the PS/2 keyboard decoder
//
// Purpose: decoder state encoding, key event record, scan code set 2
// prefix/status byte values and a fake-shift helper.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    PAUSE
  } kbd_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

  localparam int EV_W = $bits(kbd_event_t);

  localparam logic [7:0] B_E0    = 8'hE0;
  localparam logic [7:0] B_F0    = 8'hF0;
  localparam logic [7:0] B_E1    = 8'hE1;
  localparam logic [7:0] B_BAT   = 8'hAA;
  localparam logic [7:0] B_FAIL  = 8'hFC;
  localparam logic [7:0] B_ACK   = 8'hFA;
  localparam logic [7:0] B_RSND  = 8'hFE;
  localparam logic [7:0] B_OVR0  = 8'h00;
  localparam logic [7:0] B_OVR1  = 8'hFF;
  localparam logic [7:0] B_FSH_L = 8'h12;
  localparam logic [7:0] B_FSH_R = 8'h59;
  localparam logic [7:0] B_PAUSE = 8'h77;

  // E0 12 / E0 59 (and their breaks) are shift emulation around
  // extended keys; they carry no key information.
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == B_FSH_L) || (b == B_FSH_R);
  endfunction

endpackage

// File: rtl/ps2_kbd_decoder_sync_fifo.sv
// rtl/ps2_kbd_decoder_sync_fifo.sv - small synchronous FIFO for key events
//
// Purpose: DEPTH-entry, WIDTH-bit FIFO with first-word-fall-through head.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, data_i  write request and data (accepted when not full or popping)
//   pop_i           read request (ignored when empty)
//   full_o, empty_o occupancy flags
//   data_o          head entry
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - scan code set 2 decoder with event FIFO
//
// Purpose: turns received PS/2 bytes into key events {ext, brk, code},
// flags keyboard status bytes and sequence errors as one-cycle pulses.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_valid, rx_data, rx_err   byte stream from the PS/2 receiver
//   ev_valid, ev_ready          event FIFO handshake
//   ev_code, ev_ext, ev_brk     head event fields
//   bat_ok, bat_fail, ack,
//   resend, kbd_ovr, seq_err    registered one-cycle pulses
//   ev_ovf, ovf_clr             sticky event-drop flag and its clear
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter real FCLK_HZ          = 50e6,
  parameter real PREFIX_TIMEOUT_S = 2e-3,
  parameter int  FIFO_DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       bat_ok,
  output logic       bat_fail,
  output logic       ack,
  output logic       resend,
  output logic       kbd_ovr,
  output logic       seq_err,
  output logic       ev_ovf,
  input  logic       ovf_clr
);

  localparam int TC = int'($ceil(FCLK_HZ * PREFIX_TIMEOUT_S)) - 1;
  localparam int TW = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [TW-1:0] TC_V = TW'(TC);

  kbd_state_t    state_q, state_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  logic bat_ok_q, bat_fail_q, ack_q, resend_q, kbd_ovr_q, seq_err_q, ev_ovf_q;
  logic bat_ok_d, bat_fail_d, ack_d, resend_d, kbd_ovr_d, seq_err_d;

  logic       push;
  kbd_event_t push_ev, head_ev;
  logic       fifo_full, fifo_empty, pop, drop;

  // rx_valid wins over the terminal count in the same cycle.
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TC_V) && !rx_valid && !rx_err;

  // Decode is combinational so the event is written on the same edge
  // that takes the byte.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    push       = 1'b0;
    push_ev    = '0;
    bat_ok_d   = 1'b0;
    bat_fail_d = 1'b0;
    ack_d      = 1'b0;
    resend_d   = 1'b0;
    kbd_ovr_d  = 1'b0;
    seq_err_d  = 1'b0;
    if (rx_err || tmo_hit) begin
      seq_err_d = 1'b1;
      state_d   = IDLE;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          case (rx_data)
            B_E0:           state_d = EXT;
            B_F0:           state_d = BRK;
            B_E1: begin
              state_d = PAUSE;
              pcnt_d  = 3'd7;
            end
            B_BAT:          bat_ok_d   = 1'b1;
            B_FAIL:         bat_fail_d = 1'b1;
            B_ACK:          ack_d      = 1'b1;
            B_RSND:         resend_d   = 1'b1;
            B_OVR0, B_OVR1: kbd_ovr_d  = 1'b1;
            default: begin
              push    = 1'b1;
              push_ev = '{ext: 1'b0, brk: 1'b0, code: rx_data};
            end
          endcase
        end
        BRK: begin
          state_d = IDLE;
          if (rx_data == B_E0 || rx_data == B_E1 || rx_data == B_F0) begin
            seq_err_d = 1'b1;
          end else begin
            push    = 1'b1;
            push_ev = '{ext: 1'b0, brk: 1'b1, code: rx_data};
          end
        end
        EXT: begin
          state_d = IDLE;
          if (rx_data == B_F0) begin
            state_d = EXT_BRK;
          end else if (rx_data == B_E0 || rx_data == B_E1) begin
            seq_err_d = 1'b1;
          end else if (!is_fake_shift(rx_data)) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b1, brk: 1'b0, code: rx_data};
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (rx_data == B_E0 || rx_data == B_E1 || rx_data == B_F0) begin
            seq_err_d = 1'b1;
          end else if (!is_fake_shift(rx_data)) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b1, brk: 1'b1, code: rx_data};
          end
        end
        PAUSE: begin
          // Pause bytes are counted, not checked; the last one emits the key.
          pcnt_d = pcnt_q - 3'd1;
          if (pcnt_q == 3'd1) begin
            state_d = IDLE;
            push    = 1'b1;
            push_ev = '{ext: 1'b1, brk: 1'b0, code: B_PAUSE};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      tmo_q      <= '0;
      bat_ok_q   <= 1'b0;
      bat_fail_q <= 1'b0;
      ack_q      <= 1'b0;
      resend_q   <= 1'b0;
      kbd_ovr_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      ev_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      bat_ok_q   <= bat_ok_d;
      bat_fail_q <= bat_fail_d;
      ack_q      <= ack_d;
      resend_q   <= resend_d;
      kbd_ovr_q  <= kbd_ovr_d;
      seq_err_q  <= seq_err_d;
      // Saturating gap counter, only meaningful inside a sequence.
      if (state_q == IDLE || rx_valid || rx_err) begin
        tmo_q <= '0;
      end else if (tmo_q != TC_V) begin
        tmo_q <= tmo_q + 1'b1;
      end
      // A fresh drop outranks a clear in the same cycle.
      if (drop) begin
        ev_ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ev_ovf_q <= 1'b0;
      end
    end
  end

  assign pop  = ev_valid & ev_ready;
  assign drop = push & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH(EV_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (push_ev),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .data_o (head_ev)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_brk   = head_ev.brk;
  assign bat_ok   = bat_ok_q;
  assign bat_fail = bat_fail_q;
  assign ack      = ack_q;
  assign resend   = resend_q;
  assign kbd_ovr  = kbd_ovr_q;
  assign seq_err  = seq_err_q;
  assign ev_ovf   = ev_ovf_q;

endmodule
